// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and its boot loader:
// state encoding, memory geometry and the frame header decode.
package imem_pkg;
  localparam int IMEM_ADDR_WIDTH = 8;
  localparam int IMEM_DEPTH      = 1 << IMEM_ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_RUN,
    ST_ERROR
  } state_e;

  // A header of zero stands for a full-depth image.
  function automatic logic [IMEM_ADDR_WIDTH:0] n_decode(input logic [7:0] hdr);
    return (hdr == 8'd0) ? (IMEM_ADDR_WIDTH+1)'(IMEM_DEPTH)
                         : (IMEM_ADDR_WIDTH+1)'(hdr);
  endfunction
endpackage

// File: rtl/imem_array.sv
// Word-wide register array: one synchronous write port, one asynchronous
// read port, no reset so contents survive a loader reset.
module imem_array #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/imem_loader.sv
// Byte-stream boot loader in front of the instruction memory: assembles
// little-endian words, checks the XOR checksum and releases the core.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] rom_address,
  output logic [DATA_WIDTH-1:0] rom_data,
  output logic                  cpu_enable,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);
  localparam int WLW = ADDR_WIDTH + 1;

  state_e          state_q, state_d;
  logic [WLW-1:0]  n_q, n_d;
  logic [WLW-1:0]  wl_q, wl_d;
  logic [1:0]      lane_q, lane_d;
  logic [23:0]     shift_q, shift_d;
  logic [7:0]      xor_q, xor_d;

  logic                  accept;
  logic                  we;
  logic [DATA_WIDTH-1:0] wdata;
  logic [ADDR_WIDTH-1:0] waddr;

  // Gating by reset keeps the source stalled while reset is held.
  assign in_ready = reset && (state_q != ST_RUN);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wl_d    = wl_q;
    lane_d  = lane_q;
    shift_d = shift_q;
    xor_d   = xor_q;
    we      = 1'b0;
    wdata   = DATA_WIDTH'({in_data, shift_q});
    waddr   = wl_q[ADDR_WIDTH-1:0];
    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (accept) begin
          n_d     = WLW'(n_decode(in_data));
          xor_d   = 8'd0;
          lane_d  = 2'd0;
          wl_d    = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          xor_d   = xor_q ^ in_data;
          lane_d  = lane_q + 2'd1;
          shift_d = {in_data, shift_q[23:8]};
          if (lane_q == 2'd3) begin
            we   = 1'b1;
            wl_d = wl_q + WLW'(1);
            if ((wl_q + WLW'(1)) == n_q) state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (accept) state_d = (in_data == xor_q) ? ST_RUN : ST_ERROR;
      end
      ST_RUN: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      wl_q    <= '0;
      lane_q  <= 2'd0;
      shift_q <= 24'd0;
      xor_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wl_q    <= wl_d;
      lane_q  <= lane_d;
      shift_q <= shift_d;
      xor_q   <= xor_d;
    end
  end

  assign cpu_enable   = (state_q == ST_RUN);
  assign load_error   = (state_q == ST_ERROR);
  assign words_loaded = wl_q;

  imem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clk_i  (clk),
    .we_i   (we),
    .waddr_i(waddr),
    .wdata_i(wdata),
    .raddr_i(rom_address),
    .rdata_o(rom_data)
  );
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a per-cycle vector table for the basic
// and bad-checksum frames, then hand-written multi-cycle sequences.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  rom_address = 8'd0;
  logic [31:0] rom_data;
  logic        cpu_enable;
  logic        load_error;
  logic [8:0]  words_loaded;

  int checks = 0;
  int errors = 0;

  imem_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .rom_address(rom_address), .rom_data(rom_data),
    .cpu_enable(cpu_enable), .load_error(load_error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    logic        v;
    logic        r;
    logic        rdy;
    logic        en;
    logic        err;
    logic [8:0]  wl;
    logic        crom;
    logic [31:0] rom;
  } vec_t;

  vec_t tv[24];

  function automatic vec_t mk(logic [7:0] d, logic v, logic r, logic rdy, logic en,
                              logic err, logic [8:0] wl, logic crom, logic [31:0] rom);
    vec_t t;
    t.d = d; t.v = v; t.r = r; t.rdy = rdy; t.en = en; t.err = err;
    t.wl = wl; t.crom = crom; t.rom = rom;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offers a byte until accepted; pct is the chance in_valid is high per cycle.
  task automatic send_byte(input logic [7:0] b, input int pct);
    bit done = 0;
    int tries = 0;
    while (!done && tries < 60) begin
      @(negedge clk);
      in_data  = b;
      in_valid = ($urandom_range(99) < pct);
      #1;
      done = in_valid && in_ready;
      @(posedge clk);
      tries++;
    end
    if (!done) chk("send_timeout", 32'(tries), 32'd0);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      reset = 1'b0; in_valid = 1'b0;
      #1;
      chk("rst_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    chk("rst_en", 32'(cpu_enable), 32'd0);
    chk("rst_err", 32'(load_error), 32'd0);
    chk("rst_wl", 32'(words_loaded), 32'd0);
    reset = 1'b1;
  endtask

  task automatic send_frame1(input int pct);
    send_byte(8'h01, pct); send_byte(8'hEF, pct); send_byte(8'hBE, pct);
    send_byte(8'hAD, pct); send_byte(8'hDE, pct); send_byte(8'h22, pct);
  endtask

  initial begin
    tv[0]  = mk(8'h01, 1, 1, 1, 0, 0, 9'd0, 0, 32'h0);
    tv[1]  = mk(8'hEF, 1, 1, 1, 0, 0, 9'd0, 0, 32'h0);
    tv[2]  = mk(8'hBE, 1, 1, 1, 0, 0, 9'd0, 0, 32'h0);
    tv[3]  = mk(8'hAD, 1, 1, 1, 0, 0, 9'd0, 0, 32'h0);
    tv[4]  = mk(8'hDE, 1, 1, 1, 0, 0, 9'd0, 0, 32'h0);
    tv[5]  = mk(8'h22, 1, 1, 1, 0, 0, 9'd1, 1, 32'hDEADBEEF);
    tv[6]  = mk(8'h00, 1, 1, 0, 1, 0, 9'd1, 1, 32'hDEADBEEF);
    tv[7]  = mk(8'hFF, 1, 1, 0, 1, 0, 9'd1, 1, 32'hDEADBEEF);
    tv[8]  = mk(8'h00, 0, 0, 0, 1, 0, 9'd1, 0, 32'h0);
    tv[9]  = mk(8'h00, 0, 0, 0, 0, 0, 9'd0, 1, 32'hDEADBEEF);
    tv[10] = mk(8'h01, 1, 1, 1, 0, 0, 9'd0, 0, 32'h0);
    tv[11] = mk(8'h13, 1, 1, 1, 0, 0, 9'd0, 0, 32'h0);
    tv[12] = mk(8'h00, 1, 1, 1, 0, 0, 9'd0, 0, 32'h0);
    tv[13] = mk(8'h00, 1, 1, 1, 0, 0, 9'd0, 0, 32'h0);
    tv[14] = mk(8'h00, 1, 1, 1, 0, 0, 9'd0, 0, 32'h0);
    tv[15] = mk(8'h00, 1, 1, 1, 0, 0, 9'd1, 1, 32'h00000013);
    tv[16] = mk(8'h01, 1, 1, 1, 0, 1, 9'd1, 0, 32'h0);
    tv[17] = mk(8'h13, 1, 1, 1, 0, 0, 9'd0, 0, 32'h0);
    tv[18] = mk(8'h00, 1, 1, 1, 0, 0, 9'd0, 0, 32'h0);
    tv[19] = mk(8'h00, 1, 1, 1, 0, 0, 9'd0, 0, 32'h0);
    tv[20] = mk(8'h00, 1, 1, 1, 0, 0, 9'd0, 0, 32'h0);
    tv[21] = mk(8'h13, 1, 1, 1, 0, 0, 9'd1, 1, 32'h00000013);
    tv[22] = mk(8'h00, 0, 1, 0, 1, 0, 9'd1, 1, 32'h00000013);
    tv[23] = mk(8'hFF, 1, 1, 0, 1, 0, 9'd1, 1, 32'h00000013);

    // Power-on reset.
    @(negedge clk);
    #1;
    chk("por_ready", 32'(in_ready), 32'd0);
    chk("por_en", 32'(cpu_enable), 32'd0);
    chk("por_err", 32'(load_error), 32'd0);
    chk("por_wl", 32'(words_loaded), 32'd0);
    @(posedge clk);

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      in_data = tv[i].d; in_valid = tv[i].v; reset = tv[i].r;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'(tv[i].rdy));
      chk($sformatf("v%0d_en", i), 32'(cpu_enable), 32'(tv[i].en));
      chk($sformatf("v%0d_err", i), 32'(load_error), 32'(tv[i].err));
      chk($sformatf("v%0d_wl", i), 32'(words_loaded), 32'(tv[i].wl));
      if (tv[i].crom) chk($sformatf("v%0d_rom", i), rom_data, tv[i].rom);
      @(posedge clk);
    end

    // Reset in the middle of a two-word frame.
    do_reset(2);
    send_byte(8'h02, 100); send_byte(8'h11, 100); send_byte(8'h22, 100);
    send_byte(8'h33, 100); send_byte(8'h44, 100); send_byte(8'h55, 100);
    idle();
    chk("mid_wl", 32'(words_loaded), 32'd1);
    do_reset(2);
    idle();
    chk("mid_ready", 32'(in_ready), 32'd1);
    chk("mid_en", 32'(cpu_enable), 32'd0);
    chk("mid_word0", rom_data, 32'h44332211);
    send_byte(8'h01, 100); send_byte(8'h78, 100); send_byte(8'h56, 100);
    send_byte(8'h34, 100); send_byte(8'h12, 100); send_byte(8'h08, 100);
    idle();
    chk("fresh_en", 32'(cpu_enable), 32'd1);
    chk("fresh_word0", rom_data, 32'h12345678);

    // RUN lockout.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_data = 8'hFF; in_valid = 1'b1;
      #1;
      chk("lock_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
    end
    idle();
    chk("lock_en", 32'(cpu_enable), 32'd1);
    chk("lock_word0", rom_data, 32'h12345678);
    chk("lock_wl", 32'(words_loaded), 32'd1);

    // Full-depth frame: every word's bytes equal its index, so the XOR is 0.
    do_reset(1);
    send_byte(8'h00, 100);
    for (int w = 0; w < 256; w++)
      for (int b = 0; b < 4; b++) send_byte(8'(w), 100);
    idle();
    chk("full_wl", 32'(words_loaded), 32'd256);
    chk("full_en_pre", 32'(cpu_enable), 32'd0);
    send_byte(8'h00, 100);
    idle();
    chk("full_en", 32'(cpu_enable), 32'd1);
    for (int a = 0; a < 256; a += 85) begin
      rom_address = 8'(a);
      #1;
      chk($sformatf("full_word%0d", a), rom_data, 32'(a) * 32'h01010101);
    end
    rom_address = 8'd255;
    #1;
    chk("full_word255", rom_data, 32'hFFFFFFFF);

    // Stalled source at 30% duty.
    do_reset(1);
    send_frame1(30);
    idle();
    chk("stall_en", 32'(cpu_enable), 32'd1);
    chk("stall_wl", 32'(words_loaded), 32'd1);
    chk("stall_ready", 32'(in_ready), 32'd0);
    rom_address = 8'd0;
    #1;
    chk("stall_word0", rom_data, 32'hDEADBEEF);
    rom_address = 8'd1;
    #1;
    chk("stall_word1", rom_data, 32'h01010101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
